// File: rtl/hazard_if.sv
// Control bundle between the five-stage core and its pipeline sequencer.
// The sequencer takes the slave side; the core (or a bench) takes the master side.
interface hazard_if;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_halt;
  logic [2:0]  ex_rd;
  logic        ex_read_mem;
  logic        ex_write_reg;
  logic        ex_branch_taken;
  logic        mem_access;
  logic        mem_ack;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_req;
  logic [2:0]  state_o;
  logic        halted;
  logic        err_o;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_halt,
           ex_rd, ex_read_mem, ex_write_reg, ex_branch_taken,
           mem_access, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_req, state_o, halted, err_o, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_halt,
           ex_rd, ex_read_mem, ex_write_reg, ex_branch_taken,
           mem_access, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_req, state_o, halted, err_o, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, load-use bubbles, branch flush,
// data-memory freeze with timeout, and halt drain for the 8-bit five-stage core.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned LOAD_BUBBLES = 1
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave hz
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    MEM_WAIT   = 3'd2,
    DRAIN      = 3'd3,
    HALT       = 3'd4
  } state_t;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '{default: 1'b0};
  localparam ctrl_t CTRL_FLOW   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_HALT   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);
  localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);

  state_t      state, next_state;
  state_t      ret_state, next_ret;
  logic [7:0]  wait_cnt, next_wait;
  logic [1:0]  cnt, next_cnt;
  logic        err, next_err;
  logic        active;
  logic [15:0] stalls;
  ctrl_t       ctrl;

  logic mem_req;
  logic mem_stall;
  logic load_use;

  // Controls stay quiet until the first clock edge after reset release.
  assign mem_req   = active & hz.mem_access & (state != HALT);
  assign mem_stall = mem_req & ~hz.mem_ack;
  assign load_use  = hz.ex_read_mem & hz.ex_write_reg &
                     ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                      (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      wait_cnt  <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      active    <= 1'b0;
      stalls    <= '0;
    end else begin
      state     <= next_state;
      ret_state <= next_ret;
      wait_cnt  <= next_wait;
      cnt       <= next_cnt;
      err       <= next_err;
      active    <= 1'b1;
      if (active && !ctrl.pc && state != HALT && stalls != 16'hFFFF)
        stalls <= stalls + 16'd1;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_ret   = ret_state;
    next_wait  = wait_cnt;
    next_cnt   = cnt;
    next_err   = err;
    if (active) begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            next_ret   = RUN;
            next_state = MEM_WAIT;
            next_wait  = 8'd1;
          end else if (!hz.ex_branch_taken) begin
            if (load_use) begin
              if (LOAD_BUBBLES > 1) begin
                next_state = LOAD_STALL;
                next_cnt   = BUB_INIT;
              end
            end else if (hz.id_halt) begin
              next_state = DRAIN;
              next_cnt   = 2'd3;
            end
          end
        end
        LOAD_STALL, DRAIN: begin
          // Counter is held across a memory wait and resumed on the ack.
          if (mem_stall) begin
            next_ret   = state;
            next_state = MEM_WAIT;
            next_wait  = 8'd1;
          end else begin
            next_cnt = cnt - 2'd1;
            if (cnt == 2'd1)
              next_state = (state == LOAD_STALL) ? RUN : HALT;
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ack) begin
            next_state = ret_state;
          end else if (wait_cnt >= TIMEOUT) begin
            next_err   = 1'b1;
            next_state = HALT;
          end else begin
            next_wait = wait_cnt + 8'd1;
          end
        end
        HALT:    next_state = HALT;
        default: next_state = RUN;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_FREEZE;
    if (active) begin
      unique case (state)
        RUN: begin
          if (mem_stall)               ctrl = CTRL_FREEZE;
          else if (hz.ex_branch_taken) ctrl = CTRL_BRANCH;
          else if (load_use)           ctrl = CTRL_BUBBLE;
          else if (hz.id_halt)         ctrl = CTRL_HALT;
          else                         ctrl = CTRL_FLOW;
        end
        LOAD_STALL, DRAIN: ctrl = mem_stall ? CTRL_FREEZE : CTRL_BUBBLE;
        MEM_WAIT:          ctrl = hz.mem_ack ? CTRL_FLOW : CTRL_FREEZE;
        default:           ctrl = CTRL_FREEZE;
      endcase
    end
  end

  assign hz.pc_en       = ctrl.pc;
  assign hz.if_id_en    = ctrl.if_id;
  assign hz.id_ex_en    = ctrl.id_ex;
  assign hz.ex_mem_en   = ctrl.ex_mem;
  assign hz.mem_wb_en   = ctrl.mem_wb;
  assign hz.if_id_flush = ctrl.if_id_flush;
  assign hz.id_ex_flush = ctrl.id_ex_flush;
  assign hz.mem_req     = mem_req;
  assign hz.state_o     = state;
  assign hz.halted      = (state == HALT);
  assign hz.err_o       = err;
  assign hz.stall_cnt   = stalls;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes model predictions into a
// queue, a monitor on the falling edge pops and compares the DUT outputs.
module tb_hazard_ctrl;
  localparam int MEM_TIMEOUT  = 5;
  localparam int LOAD_BUBBLES = 2;

  localparam int S_RUN = 0, S_LS = 1, S_MW = 2, S_DR = 3, S_HALT = 4;

  typedef struct {
    bit       rst;
    bit [2:0] rs1, rs2, rd;
    bit       u1, u2, halt, rm, wr, br, acc, ack;
  } stim_t;

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id_flush, id_ex_flush}
  typedef struct {
    bit [4:0] en;
    bit [1:0] fl;
    bit       req;
    int       state;
    bit       halted;
    bit       err;
    int       stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if hz();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .LOAD_BUBBLES(LOAD_BUBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  int   passed;
  int   total;
  exp_t exp_q[$];

  // Reference model: pipeline mode plus how many bubbles / drain slots /
  // wait cycles remain.
  int m_mode, m_resume, bubbles_left, drain_left, m_waited, m_stalls;
  bit m_err, m_active;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic model_reset();
    m_mode = S_RUN; m_resume = S_RUN;
    bubbles_left = 0; drain_left = 0; m_waited = 0;
    m_stalls = 0; m_err = 1'b0; m_active = 1'b0;
  endtask

  task automatic model_cycle(input stim_t s, output exp_t e);
    bit wait_hit, lu;
    if (!s.rst) model_reset();
    e.en = '0; e.fl = '0; e.req = 1'b0;
    e.state = m_mode; e.halted = (m_mode == S_HALT); e.err = m_err; e.stalls = m_stalls;
    if (!s.rst) return;
    if (!m_active) begin
      m_active = 1'b1;
      return;
    end
    e.req    = s.acc && (m_mode != S_HALT);
    wait_hit = e.req && !s.ack;
    lu = s.rm && s.wr && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    case (m_mode)
      S_RUN: begin
        if (wait_hit) begin
          m_resume = S_RUN; m_mode = S_MW; m_waited = 1;
        end else if (s.br) begin
          e.en = 5'b11111; e.fl = 2'b11;
        end else if (lu) begin
          e.en = 5'b00111; e.fl = 2'b01;
          if (LOAD_BUBBLES > 1) begin m_mode = S_LS; bubbles_left = LOAD_BUBBLES - 1; end
        end else if (s.halt) begin
          e.en = 5'b01111; e.fl = 2'b10; m_mode = S_DR; drain_left = 3;
        end else begin
          e.en = 5'b11111;
        end
      end
      S_LS: begin
        if (wait_hit) begin
          m_resume = S_LS; m_mode = S_MW; m_waited = 1;
        end else begin
          e.en = 5'b00111; e.fl = 2'b01;
          bubbles_left--;
          if (bubbles_left == 0) m_mode = S_RUN;
        end
      end
      S_DR: begin
        if (wait_hit) begin
          m_resume = S_DR; m_mode = S_MW; m_waited = 1;
        end else begin
          e.en = 5'b00111; e.fl = 2'b01;
          drain_left--;
          if (drain_left == 0) m_mode = S_HALT;
        end
      end
      S_MW: begin
        if (s.ack) begin
          e.en = 5'b11111; m_mode = m_resume;
        end else if (m_waited >= MEM_TIMEOUT) begin
          m_err = 1'b1; m_mode = S_HALT;
        end else begin
          m_waited++;
        end
      end
      default: ;
    endcase
    if (!e.en[4] && e.state != S_HALT && m_stalls < 65535) m_stalls++;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.rs1  = 3'($urandom_range(0, 3));
    s.rs2  = 3'($urandom_range(0, 3));
    s.rd   = 3'($urandom_range(0, 3));
    s.u1   = ($urandom_range(0, 9) < 6);
    s.u2   = ($urandom_range(0, 9) < 5);
    s.rm   = ($urandom_range(0, 9) < 4);
    s.wr   = ($urandom_range(0, 9) < 7);
    s.br   = ($urandom_range(0, 9) < 1);
    s.halt = ($urandom_range(0, 99) < 3);
    s.acc  = ($urandom_range(0, 9) < 3);
    s.ack  = ($urandom_range(0, 99) < 65);
    if ($urandom_range(0, 199) == 0) s.rst = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    hz.id_rs1 = s.rs1; hz.id_rs2 = s.rs2;
    hz.id_uses_rs1 = s.u1; hz.id_uses_rs2 = s.u2; hz.id_halt = s.halt;
    hz.ex_rd = s.rd; hz.ex_read_mem = s.rm; hz.ex_write_reg = s.wr;
    hz.ex_branch_taken = s.br; hz.mem_access = s.acc; hz.mem_ack = s.ack;
    rst_n = s.rst;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    model_cycle(s, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    repeat (2) step(s);
    s.rst = 1'b1;
    step(s);
  endtask

  // Monitor: the DUT presents a full control word every cycle.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("enables", {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en}, 32'(e.en));
        check("flushes", {hz.if_id_flush, hz.id_ex_flush}, 32'(e.fl));
        check("mem_req", hz.mem_req, 32'(e.req));
        check("state_o", hz.state_o, 32'(e.state));
        check("halted", hz.halted, 32'(e.halted));
        check("err_o", hz.err_o, 32'(e.err));
        check("stall_cnt", hz.stall_cnt, 32'(e.stalls));
      end
    end
  end

  initial begin
    stim_t s;
    passed = 0;
    total  = 0;
    s = idle();
    s.rst = 1'b0;
    apply(s);
    model_reset();
    #2;
    check("reset_pc_en", hz.pc_en, 0);
    check("reset_mem_wb_en", hz.mem_wb_en, 0);
    check("reset_state", hz.state_o, 0);
    check("reset_stall_cnt", hz.stall_cnt, 0);
    do_reset();

    // Load-use with two bubbles, then free flow.
    s = idle(); s.rd = 3; s.rm = 1; s.wr = 1; s.rs1 = 3; s.u1 = 1;
    step(s); step(s);
    s = idle(); repeat (2) step(s);

    // Taken branch wins over a pending load-use.
    s = idle(); s.rd = 5; s.rm = 1; s.wr = 1; s.rs2 = 5; s.u2 = 1; s.br = 1;
    step(s);
    s = idle(); step(s);

    // Memory wait: ack in the fifth wait cycle (the timeout cycle).
    s = idle(); s.acc = 1;
    repeat (5) step(s);
    s.ack = 1; step(s);
    s = idle(); step(s);

    // Halt drain with a memory wait in the middle of DRAIN.
    s = idle(); s.halt = 1; step(s);
    s = idle(); step(s);
    s.acc = 1; repeat (2) step(s);
    s.ack = 1; step(s);
    s = idle(); repeat (4) step(s);
    repeat (3) step(rand_stim_no_rst());
    do_reset();

    // Timeout: no ack ever.
    s = idle(); s.acc = 1;
    repeat (9) step(s);
    do_reset();

    // Asynchronous reset in the middle of LOAD_STALL.
    s = idle(); s.rd = 2; s.rm = 1; s.wr = 1; s.rs1 = 2; s.u1 = 1;
    step(s);
    s.acc = 1; s.ack = 1;
    step(s);
    #1;
    check("in_load_stall", hz.state_o, S_LS);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_state", hz.state_o, 0);
    check("async_rst_id_ex_flush", hz.id_ex_flush, 0);
    check("async_rst_ex_mem_en", hz.ex_mem_en, 0);
    check("async_rst_mem_req", hz.mem_req, 0);
    check("async_rst_stall_cnt", hz.stall_cnt, 0);
    s = idle(); s.rst = 1'b0; step(s);
    s.rst = 1'b1; step(s);
    s = idle(); repeat (2) step(s);

    // Randomized traffic; reset is pulsed now and then once halted.
    for (int i = 0; i < 1500; i++) begin
      s = rand_stim();
      if (m_mode == S_HALT && $urandom_range(0, 3) == 0) s.rst = 1'b0;
      step(s);
    end

    for (int k = 0; k < 6 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  function automatic stim_t rand_stim_no_rst();
    stim_t s;
    s = rand_stim();
    s.rst = 1'b1;
    return s;
  endfunction

endmodule
